// File: rtl/team_06_link_pkg.sv
// team_06_link_pkg: shared constants, types and frame builder for the link transmitter.
// Contents: KEY_UP/KEY_DOWN control words, tx_state_t, FRAME_BITS, build_frame().
// Build option: TEAM06_LINK_PARITY_EN adds an even-parity bit (12-bit frame instead of 11).
package team_06_link_pkg;

    localparam logic [7:0] KEY_UP   = 8'hA5;
    localparam logic [7:0] KEY_DOWN = 8'h5A;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

`ifdef TEAM06_LINK_PARITY_EN
    localparam int FRAME_BITS = 12;
`else
    localparam int FRAME_BITS = 11;
`endif

    // Frame packed LSB-first: bit 0 leaves the wire first (start bit).
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic       ctrl,
                                                          input logic [7:0] data);
`ifdef TEAM06_LINK_PARITY_EN
        return {1'b1, ^{ctrl, data}, data, ctrl, 1'b0};
`else
        return {1'b1, data, ctrl, 1'b0};
`endif
    endfunction

endpackage

// File: rtl/team_06_sample_fifo.sv
// team_06_sample_fifo: synchronous FIFO_DEPTH x 8 sample buffer, one cycle write-to-read.
// Ports: clk, rst (async, active-high), push/din, pop/dout (head, show-ahead), full, empty, level.
// A push while full is accepted only if a pop happens in the same cycle; pop on empty is ignored.
module team_06_sample_fifo #(
    parameter  int FIFO_DEPTH = 4,
    localparam int LW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Depth is a power of two, so the pointers wrap for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/team_06_link_tx.sv
// team_06_link_tx: frames talk key-up/key-down words and mic samples onto an async serial line.
// Ports: clk, rst (async, active-high), talk, sample_valid/sample in; tx, busy, overflow, fifo_level out.
// Build option: TEAM06_LINK_PARITY_EN selects the parity-bit frame (see team_06_link_pkg).
module team_06_link_tx
    import team_06_link_pkg::*;
#(
    parameter  int BIT_CYCLES = 16,
    parameter  int FIFO_DEPTH = 4,
    localparam int LW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          talk,
    input  logic          sample_valid,
    input  logic [7:0]    sample,
    output logic          tx,
    output logic          busy,
    output logic          overflow,
    output logic [LW-1:0] fifo_level
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam int IW = $clog2(FRAME_BITS);

    tx_state_t             state;
    tx_state_t             state_nxt;
    logic                  talk_q;
    logic                  rise;
    logic                  fall;
    logic                  pend_up;
    logic                  pend_down;
    logic                  pend_up_nxt;
    logic                  pend_down_nxt;
    logic                  sel_up;
    logic                  sel_pop;
    logic                  sel_down;
    logic                  load;
    logic                  push_req;
    logic [7:0]            f_dout;
    logic                  f_full;
    logic                  f_empty;
    logic [FRAME_BITS-1:0] shreg;
    logic [CW-1:0]         bit_cnt;
    logic [IW-1:0]         bit_idx;
    logic                  bit_end;
    logic                  last_bit;
    logic [7:0]            load_data;

    assign rise     = talk && !talk_q;
    assign fall     = !talk && talk_q;
    assign push_req = sample_valid && talk;
    assign bit_end  = (bit_cnt == CW'(BIT_CYCLES - 1));
    assign last_bit = (bit_idx == IW'(FRAME_BITS - 1));
    assign load     = sel_up || sel_pop || sel_down;

    team_06_sample_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (sel_pop),
        .din   (sample),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty),
        .level (fifo_level)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state and word selection. KEY_DOWN waits for the FIFO to drain.
    always_comb begin
        state_nxt = state;
        sel_up    = 1'b0;
        sel_pop   = 1'b0;
        sel_down  = 1'b0;
        case (state)
            IDLE: begin
                if (pend_up) begin
                    sel_up    = 1'b1;
                    state_nxt = SHIFT;
                end else if (!f_empty) begin
                    sel_pop   = 1'b1;
                    state_nxt = SHIFT;
                end else if (pend_down) begin
                    sel_down  = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_end && last_bit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        tx   = (state == SHIFT) ? shreg[0] : 1'b1;
        busy = (state == SHIFT) || !f_empty || pend_up || pend_down;
    end

    // Pending key events. A flag being consumed this cycle is already on its way
    // out, so an opposing edge in that same cycle must queue the new event rather
    // than cancel the one that is leaving.
    always_comb begin
        pend_up_nxt   = pend_up && !sel_up;
        pend_down_nxt = pend_down && !sel_down;
        if (rise) begin
            if (pend_down_nxt) pend_down_nxt = 1'b0;
            else               pend_up_nxt   = 1'b1;
        end
        if (fall) begin
            if (pend_up_nxt) pend_up_nxt   = 1'b0;
            else             pend_down_nxt = 1'b1;
        end
    end

    always_comb begin
        load_data = KEY_DOWN;
        if (sel_up)       load_data = KEY_UP;
        else if (sel_pop) load_data = f_dout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            talk_q    <= 1'b0;
            pend_up   <= 1'b0;
            pend_down <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            talk_q    <= talk;
            pend_up   <= pend_up_nxt;
            pend_down <= pend_down_nxt;
            // A pop in the same cycle frees the slot, so that push is not dropped.
            overflow  <= push_req && f_full && !sel_pop;
        end
    end

    // Shifter and bit timing; idle shifts in ones so the line stays high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '1;
            bit_cnt <= '0;
            bit_idx <= '0;
        end else if (load) begin
            shreg   <= build_frame(!sel_pop, load_data);
            bit_cnt <= '0;
            bit_idx <= '0;
        end else if (state == SHIFT) begin
            if (bit_end) begin
                bit_cnt <= '0;
                bit_idx <= bit_idx + IW'(1);
                shreg   <= {1'b1, shreg[FRAME_BITS-1:1]};
            end else begin
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_team_06_link_tx.sv
// tb_team_06_link_tx: directed bench for team_06_link_tx with BIT_CYCLES=4, FIFO_DEPTH=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected frames are built independently from ctrl/data with hand-derived parity.
module tb_team_06_link_tx;

    localparam int BC = 4;
    localparam int FD = 4;
`ifdef TEAM06_LINK_PARITY_EN
    localparam int FB = 12;
`else
    localparam int FB = 11;
`endif
    localparam int FRAME_CYC = FB * BC;

    logic       clk = 1'b0;
    logic       rst;
    logic       talk;
    logic       sample_valid;
    logic [7:0] sample;
    logic       tx;
    logic       busy;
    logic       overflow;
    logic [2:0] fifo_level;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int ovf_cnt  = 0;

    team_06_link_tx #(
        .BIT_CYCLES (BC),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .talk         (talk),
        .sample_valid (sample_valid),
        .sample       (sample),
        .tx           (tx),
        .busy         (busy),
        .overflow     (overflow),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (overflow === 1'b1) ovf_cnt <= ovf_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected wire bits, index 0 first on the line.
    function automatic logic [11:0] frame_bits(input logic ctrl, input logic [7:0] d);
        logic [11:0] f;
        int          ones;
        f    = 12'hFFF;
        f[0] = 1'b0;
        f[1] = ctrl;
        ones = (ctrl) ? 1 : 0;
        for (int k = 0; k < 8; k++) begin
            f[2+k] = d[k];
            if (d[k]) ones++;
        end
`ifdef TEAM06_LINK_PARITY_EN
        f[10] = (ones % 2 == 1) ? 1'b1 : 1'b0;
        f[11] = 1'b1;
`else
        f[10] = 1'b1;
`endif
        return f;
    endfunction

    // Waits for a start bit, checks every cycle of every bit, then the gap cycle.
    // Returns at the falling edge of the gap cycle.
    task automatic expect_frame(input string tag, input logic ctrl, input logic [7:0] d,
                                output int start);
        logic [11:0] f;
        int          waited;
        f      = frame_bits(ctrl, d);
        waited = 0;
        while (tx !== 1'b0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        start = cyc;
        if (tx !== 1'b0) begin
            check({tag, "_start_timeout"}, 32'(tx), 32'd0);
            return;
        end
        for (int i = 0; i < FB; i++) begin
            for (int j = 0; j < BC; j++) begin
                check($sformatf("%s_bit%0d", tag, i), 32'(tx), 32'(f[i]));
                @(negedge clk);
            end
        end
        check({tag, "_gap"}, 32'(tx), 32'd1);
    endtask

    initial begin
        int         s0, s1, s2, s3, s4, c0, bad, ob;
        logic [7:0] vals [5];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'hEE;

        rst = 1'b1; talk = 1'b0; sample_valid = 1'b0; sample = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx",       32'(tx),         32'd1);
        check("rst_busy",     32'(busy),       32'd0);
        check("rst_overflow", 32'(overflow),   32'd0);
        check("rst_level",    32'(fifo_level), 32'd0);

        // Idle hold after reset release.
        @(posedge clk); #1 rst = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0 || fifo_level !== 3'd0) bad++;
        end
        check("idle_hold_bad_cycles", 32'(bad), 32'd0);

        // KEY_UP latency and frame, then a sample queued during it.
        @(posedge clk); #1 talk = 1'b1; c0 = cyc;
        fork
            expect_frame("key_up", 1'b1, 8'hA5, s0);
            begin
                repeat (10) @(posedge clk);
                #1 sample = 8'h80; sample_valid = 1'b1;
                @(posedge clk);
                #1 sample_valid = 1'b0;
            end
        join
        check("key_up_latency", 32'(s0 - c0), 32'd2);
        expect_frame("aud80", 1'b0, 8'h80, s1);
        check("aud80_spacing", 32'(s1 - s0), 32'(FRAME_CYC + 1));
        check("busy_after_aud80", 32'(busy), 32'd0);

        // Three samples, talk drops with two still queued: drain then KEY_DOWN.
        fork
            begin
                @(posedge clk); #1 sample = 8'h3C; sample_valid = 1'b1; c0 = cyc;
                @(posedge clk); #1 sample = 8'hC3;
                @(posedge clk); #1 sample = 8'h01;
                @(posedge clk); #1 sample_valid = 1'b0; talk = 1'b0;
            end
            begin
                expect_frame("aud3c", 1'b0, 8'h3C, s0);
                check("sample_latency", 32'(s0 - c0), 32'd2);
                expect_frame("audc3", 1'b0, 8'hC3, s1);
                check("audc3_spacing", 32'(s1 - s0), 32'(FRAME_CYC + 1));
                expect_frame("aud01", 1'b0, 8'h01, s2);
                check("aud01_spacing", 32'(s2 - s1), 32'(FRAME_CYC + 1));
                expect_frame("key_down", 1'b1, 8'h5A, s3);
                check("key_down_spacing", 32'(s3 - s2), 32'(FRAME_CYC + 1));
                check("busy_after_key_down", 32'(busy), 32'd0);
            end
        join

        // Overflow during KEY_UP, then a quick fall/rise during the first audio frame.
        @(posedge clk); #1 talk = 1'b1; c0 = cyc;
        fork
            begin
                expect_frame("key_up2", 1'b1, 8'hA5, s0);
                expect_frame("q0", 1'b0, vals[0], s1);
                expect_frame("q1", 1'b0, vals[1], s2);
                expect_frame("q2", 1'b0, vals[2], s3);
                expect_frame("q3", 1'b0, vals[3], s4);
                check("q3_spacing", 32'(s4 - s3), 32'(FRAME_CYC + 1));
                bad = 0;
                repeat (2 * FRAME_CYC) begin
                    @(negedge clk);
                    if (tx !== 1'b1) bad++;
                end
                check("no_key_frame_after_bounce", 32'(bad), 32'd0);
                check("busy_after_bounce", 32'(busy), 32'd0);
            end
            begin
                repeat (4) @(posedge clk);
                ob = ovf_cnt;
                for (int k = 0; k < 5; k++) begin
                    #1 sample = vals[k]; sample_valid = 1'b1;
                    @(posedge clk);
                end
                #1 sample_valid = 1'b0;
                @(negedge clk);
                check("level_full", 32'(fifo_level), 32'd4);
                check("overflow_pulse", 32'(overflow), 32'd1);
                @(negedge clk);
                check("overflow_clear", 32'(overflow), 32'd0);
                repeat (3) @(negedge clk);
                check("overflow_count", 32'(ovf_cnt - ob), 32'd1);
                while (cyc < c0 + 2 + FRAME_CYC + 1 + 8) @(posedge clk);
                #1 talk = 1'b0;
                repeat (2) @(posedge clk);
                #1 talk = 1'b1;
            end
        join

        // Reset mid-frame.
        @(posedge clk); #1 sample = 8'h96; sample_valid = 1'b1;
        @(posedge clk); #1 sample = 8'h69;
        @(posedge clk); #1 sample = 8'hF0;
        @(posedge clk); #1 sample_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("pre_rst_level", 32'(fifo_level), 32'd2);
        check("pre_rst_busy",  32'(busy),       32'd1);
        @(posedge clk); #2 rst = 1'b1; talk = 1'b0;
        #1;
        check("mid_rst_tx",    32'(tx),         32'd1);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_busy",  32'(busy),       32'd0);
        @(posedge clk); #1 rst = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("post_rst_idle", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/team_06_link_tx.md
# team_06_link_tx

Serial link transmitter for the radio audio path. It consumes the talk/listen state from the team_06 control FSM and 8-bit offset-binary mic samples (midpoint 128). It frames key-up/key-down control words and audio samples into an asynchronous serial stream on `tx` for the peer unit's receiver. A small sample FIFO absorbs the rate mismatch between sample strobes and the bit clock.

## Interface
Parameters:
- `BIT_CYCLES`, default 16: clk cycles per serial bit; legal minimum is 2.
- `FIFO_DEPTH`, default 4: sample FIFO entries; must be a power of two, at least 2.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `talk`  in  1  FSM state: 1 = TALK, 0 = LIST
- `sample_valid`  in  1  single-cycle strobe qualifying `sample`
- `sample`  in  8  mic audio sample, offset binary
- `tx`  out  1  serial line; idles high
- `busy`  out  1  high while shifting, while the FIFO is non-empty, or while any key event is pending
- `overflow`  out  1  one-cycle pulse when a sample is dropped because the FIFO is full
- `fifo_level`  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

## Operation
Frame format, transmitted in this order:
- start bit (0)
- ctrl bit
- d0 through d7, LSB first
- even parity over ctrl and d[7:0]
- stop bit (1)

Data and control words:
- Audio frame: ctrl=0, data = sample.
- Control frame: ctrl=1, data = KEY_UP (8'hA5) or KEY_DOWN (8'h5A).

Talk edge detection:
- `talk_q` is a registered copy of `talk`. A rise is `talk && !talk_q`; a fall is `!talk && talk_q`.
- On a rise: if `pend_down` is set, clear it and do not set `pend_up` (the link stays keyed). Otherwise set `pend_up`.
- On a fall: if `pend_up` is set, clear it and do not set `pend_down`. Otherwise set `pend_down`.

Sample acceptance:
- A sample is pushed only when `sample_valid && talk`. When `talk`=0 the strobe is ignored and no overflow is raised.
- A push while the FIFO is full drops the sample and pulses `overflow`, unless a pop occurs in the same cycle; in that case the push is accepted.

Transmitter FSM:
- IDLE: `tx`=1. The next word is chosen in this priority order: `pend_up`, then FIFO head (pop), then `pend_down` (sent only once the FIFO is empty). Choosing a word loads the shifter, clears the consumed flag or pops the FIFO, and moves to SHIFT.
- SHIFT: each bit is held for BIT_CYCLES cycles. After the last cycle of the stop bit, return to IDLE.

Boundary conditions:
- If `talk` rises in the same cycle as `sample_valid`, the sample is accepted and KEY_UP is still sent first.
- Samples left in the FIFO after a fall are drained before KEY_DOWN is sent.

## Timing
- Reset values: `tx`=1, `busy`=0, `overflow`=0, `fifo_level`=0, FSM in IDLE, FIFO empty, both pending flags clear, `talk_q`=0. Reset takes effect immediately, including mid-frame.
- Latency: when a sample is accepted, or a talk edge is detected, in cycle c with the FSM idle and nothing of higher priority queued, `tx` goes low in cycle c+2.
- Frame length: FRAME_BITS × BIT_CYCLES cycles.
- Inter-frame gap: exactly one IDLE cycle (`tx`=1) after each stop bit, even when more words are queued.
- `fifo_level` updates one cycle after a push or pop edge.
- `overflow` is high for exactly the cycle after the dropping edge.

## Configuration
- `TEAM06_LINK_PARITY_EN` defined: the parity bit is included and FRAME_BITS = 12.
- `TEAM06_LINK_PARITY_EN` undefined: the parity bit is omitted; the stop bit follows d7 directly and FRAME_BITS = 11. All other behaviour is unchanged.

## Structure
- Package `team_06_link_pkg` holds:
  - KEY_UP and KEY_DOWN constants;
  - the `tx_state_t` enum (IDLE, SHIFT);
  - FRAME_BITS, derived under the parity macro.
- Sub-module `team_06_sample_fifo` is a synchronous FIFO, FIFO_DEPTH × 8:
  - inputs: push, pop, din;
  - outputs: dout, full, empty, level;
  - it supports push and pop in the same cycle when full.
- The top level contains edge detection, the pending flags, word selection, the shifter and the bit counters.

## Test plan
All scenarios use BIT_CYCLES=4 and FIFO_DEPTH=4 unless noted.
1. Reset release, then hold idle for 100 cycles: `tx`=1, `busy`=0, `overflow`=0, `fifo_level`=0 throughout.
2. Raise `talk` in cycle c → `tx`=0 at c+2, followed by the frame 0,1,A5 LSB-first,1,1. Then push sample 8'h80 → audio frame 0,0,00000001,1,1 after the one-cycle gap.
3. Lower `talk` while two samples are queued → both audio frames are sent, then KEY_DOWN (0,1,5A LSB-first,1,1), then `busy`=0.
4. During the KEY_UP frame, push five samples on consecutive cycles → `fifo_level`=4, and `overflow` pulses once for the fifth sample.
5. During an audio frame, drop `talk` and raise it again 2 cycles later → no KEY_DOWN and no KEY_UP frame appears; the queued samples are still sent.
6. Assert `rst` mid-frame → `tx`=1 immediately and `fifo_level`=0. Rebuild with the macro undefined → frames are 11 bits with no parity bit.
